// File: rtl/ghr_fold_sequencer.sv
// ghr_fold_sequencer
//   Keeps the speculative global history register (GHR) and its XOR-folded
//   index hash. Predicted branches update the fold incrementally in one cycle.
//   A backend restore reloads the GHR, and a REFOLD walk then rebuilds the
//   fold one FOLD_LEN chunk per cycle.
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   upd_valid_i      speculative outcome valid
//   upd_taken_i      outcome bit shifted into the GHR
//   upd_ready_o      update accepted this cycle (combinational)
//   restore_valid_i  mispredict restore request (wins over updates)
//   restore_hist_i   full history to load on restore
//   ghr_o            current GHR, bit 0 newest
//   folded_o         folded hash of ghr_o, meaningful when folded_valid_o = 1
//   folded_valid_o   folded_o matches ghr_o
//   busy_o           REFOLD in progress
module ghr_fold_sequencer #(
    parameter int unsigned HIST_LEN = 64,
    parameter int unsigned FOLD_LEN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upd_valid_i,
    input  logic                upd_taken_i,
    output logic                upd_ready_o,
    input  logic                restore_valid_i,
    input  logic [HIST_LEN-1:0] restore_hist_i,
    output logic [HIST_LEN-1:0] ghr_o,
    output logic [FOLD_LEN-1:0] folded_o,
    output logic                folded_valid_o,
    output logic                busy_o
);

    localparam int unsigned NUM_CHUNKS = (HIST_LEN + FOLD_LEN - 1) / FOLD_LEN;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned PAD_LEN    = NUM_CHUNKS * FOLD_LEN;
    // Fold position the evicted bit lands on after the rotate.
    localparam int unsigned EVICT_POS  = HIST_LEN % FOLD_LEN;

    typedef enum logic {
        IDLE   = 1'b0,
        REFOLD = 1'b1
    } state_e;

    state_e              state_q;
    logic [HIST_LEN-1:0] ghr_q;
    logic [FOLD_LEN-1:0] folded_q;
    logic [FOLD_LEN-1:0] acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                valid_q;

    logic [PAD_LEN-1:0]  ghr_pad;
    logic [FOLD_LEN-1:0] chunk_d;
    logic [FOLD_LEN-1:0] acc_d;
    logic [FOLD_LEN-1:0] folded_inc_d;
    logic                upd_fire;

    assign upd_ready_o    = (state_q == IDLE) & ~restore_valid_i;
    assign upd_fire       = upd_valid_i & upd_ready_o;
    assign ghr_o          = ghr_q;
    assign folded_o       = folded_q;
    assign folded_valid_o = valid_q;
    assign busy_o         = (state_q == REFOLD);

    // Zero-extend so the top chunk is padded with zeros.
    assign ghr_pad = PAD_LEN'(ghr_q);

    // Chunk selected by the REFOLD counter, and the running accumulator.
    always_comb begin
        chunk_d = '0;
        for (int unsigned k = 0; k < NUM_CHUNKS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                chunk_d = ghr_pad[k*FOLD_LEN +: FOLD_LEN];
            end
        end
        acc_d = acc_q ^ chunk_d;
    end

    // Incremental fold: rotate moves every retained bit to its new fold slot;
    // the new bit enters at 0 and the evicted bit's rotated copy is cancelled.
    always_comb begin
        folded_inc_d = {folded_q[FOLD_LEN-2:0], folded_q[FOLD_LEN-1]}
                     ^ FOLD_LEN'(upd_taken_i)
                     ^ (FOLD_LEN'(ghr_q[HIST_LEN-1]) << EVICT_POS);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ghr_q    <= '0;
            folded_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b1;
        end else if (restore_valid_i) begin
            state_q <= REFOLD;
            ghr_q   <= restore_hist_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (upd_fire) begin
                        ghr_q    <= {ghr_q[HIST_LEN-2:0], upd_taken_i};
                        folded_q <= folded_inc_d;
                    end
                end
                REFOLD: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
                        folded_q <= acc_d;
                        valid_q  <= 1'b1;
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghr_fold_sequencer.sv
// Directed and random bench for ghr_fold_sequencer: a 64/8 instance driven by
// a history/refold-countdown model, plus a 10/8 instance for the padded case.
module tb_ghr_fold_sequencer;

    localparam int unsigned HL = 64;
    localparam int unsigned FL = 8;
    localparam int         NC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          upd_valid, upd_taken, restore_valid;
    logic [HL-1:0] restore_hist;
    logic          upd_ready_o, folded_valid_o, busy_o;
    logic [HL-1:0] ghr_o;
    logic [FL-1:0] folded_o;

    logic          u10_valid, u10_taken, r10_valid;
    logic [9:0]    r10_hist;
    logic          ready10, fvalid10, busy10;
    logic [9:0]    ghr10;
    logic [7:0]    fold10;

    int            total = 0;
    int            bad   = 0;
    logic [HL-1:0] m_ghr;
    int            m_cnt;

    always #5 clk = ~clk;

    ghr_fold_sequencer #(.HIST_LEN(64), .FOLD_LEN(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid_i(upd_valid), .upd_taken_i(upd_taken), .upd_ready_o(upd_ready_o),
        .restore_valid_i(restore_valid), .restore_hist_i(restore_hist),
        .ghr_o(ghr_o), .folded_o(folded_o), .folded_valid_o(folded_valid_o), .busy_o(busy_o)
    );

    ghr_fold_sequencer #(.HIST_LEN(10), .FOLD_LEN(8)) u_dut10 (
        .clk(clk), .rst_n(rst_n),
        .upd_valid_i(u10_valid), .upd_taken_i(u10_taken), .upd_ready_o(ready10),
        .restore_valid_i(r10_valid), .restore_hist_i(r10_hist),
        .ghr_o(ghr10), .folded_o(fold10), .folded_valid_o(fvalid10), .busy_o(busy10)
    );

    function automatic logic [7:0] fold64(input logic [63:0] h);
        logic [7:0] f;
        f = 8'h00;
        for (int i = 0; i < 8; i++) f = f ^ h[i*8 +: 8];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock on the 64-bit instance with model tracking and per-cycle checks.
    task automatic step(input logic uv, input logic ut, input logic rv, input logic [63:0] rh);
        upd_valid     = uv;
        upd_taken     = ut;
        restore_valid = rv;
        restore_hist  = rh;
        #1;
        chk("ready", 64'(upd_ready_o), 64'(m_cnt == 0 && !rv));
        @(posedge clk);
        #2;
        if (rv) begin
            m_ghr = rh;
            m_cnt = NC;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (uv) begin
            m_ghr = {m_ghr[62:0], ut};
        end
        chk("ghr", ghr_o, m_ghr);
        chk("valid", 64'(folded_valid_o), 64'(m_cnt == 0));
        chk("busy", 64'(busy_o), 64'(m_cnt != 0));
        if (m_cnt == 0) chk("fold", 64'(folded_o), 64'(fold64(m_ghr)));
        upd_valid     = 1'b0;
        restore_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        upd_valid = 1'b0; upd_taken = 1'b0; restore_valid = 1'b0; restore_hist = '0;
        u10_valid = 1'b0; u10_taken = 1'b0; r10_valid = 1'b0; r10_hist = '0;
        m_ghr = '0;
        m_cnt = 0;

        // Reset defaults
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("rst_ghr", ghr_o, 64'h0);
        chk("rst_fold", 64'(folded_o), 64'h00);
        chk("rst_valid", 64'(folded_valid_o), 64'h1);
        chk("rst_ready", 64'(upd_ready_o), 64'h1);
        chk("rst_busy", 64'(busy_o), 64'h0);

        // Taken updates then a not-taken
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
        chk("t2_ghr8", ghr_o, 64'hFF);
        chk("t2_fold8", 64'(folded_o), 64'hFF);
        for (int i = 0; i < 56; i++) step(1'b1, 1'b1, 1'b0, '0);
        chk("t2_ghr64", ghr_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_fold64", 64'(folded_o), 64'h00);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("t2_ghr65", ghr_o, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t2_fold65", 64'(folded_o), 64'h01);

        // Restore and full REFOLD walk with updates attempted throughout
        step(1'b0, 1'b0, 1'b1, 64'hFF00_0000_0000_0001);
        for (int i = 0; i < 8; i++) begin
            chk("t3_busy", 64'(busy_o), 64'h1);
            step(1'b1, 1'b1, 1'b0, '0);
        end
        chk("t3_busy_end", 64'(busy_o), 64'h0);
        chk("t3_fold", 64'(folded_o), 64'hFE);
        chk("t3_valid", 64'(folded_valid_o), 64'h1);
        chk("t3_ghr", ghr_o, 64'hFF00_0000_0000_0001);

        // Restore during REFOLD restarts the walk
        step(1'b0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_00FF);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            chk("t4_notyet", 64'(folded_valid_o), 64'h0);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t4_valid", 64'(folded_valid_o), 64'h1);
        chk("t4_fold", 64'(folded_o), 64'hFF);

        // Restore and update together: restore wins
        upd_valid = 1'b1; upd_taken = 1'b1; restore_valid = 1'b1; restore_hist = 64'hA5;
        #1;
        chk("t5_ready", 64'(upd_ready_o), 64'h0);
        step(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_00A5);
        chk("t5_ghr", ghr_o, 64'hA5);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, '0);
        chk("t5_fold", 64'(folded_o), 64'hA5);

        // 10-bit history, padded top chunk
        r10_valid = 1'b1; r10_hist = 10'h3FF;
        step(1'b0, 1'b0, 1'b0, '0);
        r10_valid = 1'b0;
        chk("t6_busy", 64'(busy10), 64'h1);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t6_notyet", 64'(fvalid10), 64'h0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t6_valid", 64'(fvalid10), 64'h1);
        chk("t6_fold", 64'(fold10), 64'hFC);
        u10_valid = 1'b1; u10_taken = 1'b1;
        #1;
        chk("t6_ready", 64'(ready10), 64'h1);
        step(1'b0, 1'b0, 1'b0, '0);
        u10_valid = 1'b0;
        chk("t6_ghr_upd", 64'(ghr10), 64'h3FF);
        chk("t6_fold_upd", 64'(fold10), 64'hFC);
        u10_valid = 1'b1; u10_taken = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0);
        u10_valid = 1'b0;
        chk("t6_ghr_nt", 64'(ghr10), 64'h3FE);
        chk("t6_fold_nt", 64'(fold10), 64'hFD);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 24) == 0), {$urandom(), $urandom()});
        end

        // Reset in the middle of a REFOLD
        step(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234);
        step(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_ghr = '0;
        m_cnt = 0;
        chk("rst2_busy", 64'(busy_o), 64'h0);
        chk("rst2_valid", 64'(folded_valid_o), 64'h1);
        chk("rst2_ghr", ghr_o, 64'h0);
        chk("rst2_fold", 64'(folded_o), 64'h00);
        step(1'b1, 1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
